// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - ARM decode stage with register file, condition check and ID/EX register
//
// Purpose: decodes the instruction held in ID, reads its operands from the
// internal register file, checks the condition field against NZCV, and
// registers everything into ID/EX for the EX stage.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   freeze, flush, hazard    ID/EX hold, ID/EX clear, bubble the current instruction
//   pc_in, instruction       PC+4 and instruction word in ID
//   status                   NZCV (bit3=N .. bit0=V)
//   wb_en_in/wb_dest/wb_value  register-file write-back port
//   id_src1/id_src2/id_two_src/id_use_src1  combinational source info for the hazard unit
//   ex_*                     registered ID/EX outputs

module id_stage_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 15,
  parameter int RF_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction,
  input  logic [3:0]        status,
  input  logic              wb_en_in,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [3:0]        id_src1,
  output logic [3:0]        id_src2,
  output logic              id_two_src,
  output logic              id_use_src1,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [3:0]        ex_alu_cmd,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic              ex_wb_en,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_status_en,
  output logic              ex_imm,
  output logic              ex_carry,
  output logic [23:0]       ex_b_imm,
  output logic [11:0]       ex_shift_op
);

  localparam logic [4:0] LP_NREGS = 5'(NUM_REGS);

  // Always 16 entries so a 4-bit index never overruns; entries at or above
  // NUM_REGS are never written and read back as 0.
  logic [DATA_W-1:0] r_rf [16];

  logic [1:0] w_mode;
  logic [3:0] w_op;
  logic       w_s;
  logic       w_i;
  logic       w_is_str;
  logic       w_src1_ok;
  logic       w_src2_ok;
  logic       w_wb_ok;
  logic       w_cond_ok;
  logic       w_bubble;
  logic [DATA_W-1:0] w_val_rn;
  logic [DATA_W-1:0] w_val_rm;
  logic [3:0] w_alu_cmd;
  logic       w_wb_en;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_branch;
  logic       w_status_en;

  assign w_mode   = instruction[27:26];
  assign w_op     = instruction[24:21];
  assign w_s      = instruction[20];
  assign w_i      = instruction[25];
  assign w_is_str = (w_mode == 2'b01) & ~w_s;

  // STR takes its store data from Rd, so Rd is the second source.
  assign id_src1     = instruction[19:16];
  assign id_src2     = w_is_str ? instruction[15:12] : instruction[3:0];
  assign id_two_src  = ((w_mode == 2'b00) & ~w_i) | w_is_str;
  assign id_use_src1 = ~(((w_mode == 2'b00) & ((w_op == 4'b1101) | (w_op == 4'b1111)))
                         | (w_mode == 2'b10));

  assign w_src1_ok = {1'b0, id_src1} < LP_NREGS;
  assign w_src2_ok = {1'b0, id_src2} < LP_NREGS;
  assign w_wb_ok   = {1'b0, wb_dest} < LP_NREGS;

  always_comb begin
    w_val_rn = '0;
    if (w_src1_ok) begin
      w_val_rn = r_rf[id_src1];
      if ((RF_BYPASS != 0) && wb_en_in && (wb_dest == id_src1)) begin
        w_val_rn = wb_value;
      end
    end
  end

  always_comb begin
    w_val_rm = '0;
    if (w_src2_ok) begin
      w_val_rm = r_rf[id_src2];
      if ((RF_BYPASS != 0) && wb_en_in && (wb_dest == id_src2)) begin
        w_val_rm = wb_value;
      end
    end
  end

  // status = {N, Z, C, V}
  always_comb begin
    w_cond_ok = 1'b0;
    case (instruction[31:28])
      4'b0000: w_cond_ok = status[2];
      4'b0001: w_cond_ok = ~status[2];
      4'b0010: w_cond_ok = status[1];
      4'b0011: w_cond_ok = ~status[1];
      4'b0100: w_cond_ok = status[3];
      4'b0101: w_cond_ok = ~status[3];
      4'b0110: w_cond_ok = status[0];
      4'b0111: w_cond_ok = ~status[0];
      4'b1000: w_cond_ok = status[1] & ~status[2];
      4'b1001: w_cond_ok = ~status[1] | status[2];
      4'b1010: w_cond_ok = (status[3] == status[0]);
      4'b1011: w_cond_ok = (status[3] != status[0]);
      4'b1100: w_cond_ok = ~status[2] & (status[3] == status[0]);
      4'b1101: w_cond_ok = status[2] | (status[3] != status[0]);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_cmd   = 4'b0000;
    w_wb_en     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_status_en = 1'b0;
    case (w_mode)
      2'b00: begin
        w_wb_en     = 1'b1;
        w_status_en = w_s;
        case (w_op)
          4'b1101: w_alu_cmd = 4'b0001;
          4'b1111: w_alu_cmd = 4'b1001;
          4'b0100: w_alu_cmd = 4'b0010;
          4'b0101: w_alu_cmd = 4'b0011;
          4'b0010: w_alu_cmd = 4'b0100;
          4'b0110: w_alu_cmd = 4'b0101;
          4'b0000: w_alu_cmd = 4'b0110;
          4'b1100: w_alu_cmd = 4'b0111;
          4'b0001: w_alu_cmd = 4'b1000;
          4'b1010: begin
            w_alu_cmd   = 4'b0100;
            w_wb_en     = 1'b0;
            w_status_en = 1'b1;
          end
          4'b1000: begin
            w_alu_cmd   = 4'b0110;
            w_wb_en     = 1'b0;
            w_status_en = 1'b1;
          end
          default: begin
            w_wb_en     = 1'b0;
            w_status_en = 1'b0;
          end
        endcase
      end
      2'b01: begin
        w_alu_cmd   = 4'b0010;
        w_mem_read  = w_s;
        w_wb_en     = w_s;
        w_mem_write = ~w_s;
      end
      2'b10: w_branch = 1'b1;
      default: ;
    endcase
  end

  assign w_bubble = ~w_cond_ok | hazard;

  // Write-back is independent of freeze/flush: the instruction writing back
  // is already past EX and must retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en_in && w_wb_ok) begin
      r_rf[wb_dest] <= wb_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      ex_pc        <= '0;
      ex_val_rn    <= '0;
      ex_val_rm    <= '0;
      ex_alu_cmd   <= '0;
      ex_dest      <= '0;
      ex_src1      <= '0;
      ex_src2      <= '0;
      ex_wb_en     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_status_en <= 1'b0;
      ex_imm       <= 1'b0;
      ex_carry     <= 1'b0;
      ex_b_imm     <= '0;
      ex_shift_op  <= '0;
    end else if (!freeze) begin
      ex_pc        <= pc_in;
      ex_val_rn    <= w_val_rn;
      ex_val_rm    <= w_val_rm;
      ex_dest      <= instruction[15:12];
      ex_src1      <= id_src1;
      ex_src2      <= id_src2;
      ex_imm       <= w_i;
      ex_carry     <= status[1];
      ex_b_imm     <= instruction[23:0];
      ex_shift_op  <= instruction[11:0];
      // A bubble only kills the side effects; data fields still flow.
      ex_alu_cmd   <= w_bubble ? 4'b0000 : w_alu_cmd;
      ex_wb_en     <= w_wb_en     & ~w_bubble;
      ex_mem_read  <= w_mem_read  & ~w_bubble;
      ex_mem_write <= w_mem_write & ~w_bubble;
      ex_branch    <= w_branch    & ~w_bubble;
      ex_status_en <= w_status_en & ~w_bubble;
    end
  end

endmodule
